// File: rtl/rgb_layer_mixer.sv
// Layer colour mixer: masks and merges per-layer RGB sources, applies blanking,
// and scales the result by a frame-stepped fade level ahead of the VGA DAC.
module rgb_layer_mixer #(
  parameter int N_LAYERS        = 13,
  parameter int COLOR_W         = 8,
  parameter int LEVEL_W         = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]             layer_hit,
  input  logic [N_LAYERS-1:0]             layer_en,
  input  logic                            mode,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic                            video_on,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            fade_req,
  input  logic                            fade_dir,
  output logic [COLOR_W-1:0]              VGA_R,
  output logic [COLOR_W-1:0]              VGA_G,
  output logic [COLOR_W-1:0]              VGA_B,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic                            fade_busy,
  output logic                            fade_done,
  output logic [LEVEL_W:0]                level
);

  localparam int PIX_W  = 3 * COLOR_W;
  localparam int PROD_W = COLOR_W + LEVEL_W + 1;
  localparam int CNT_W  = $clog2(FRAMES_PER_STEP + 1);

  localparam logic [LEVEL_W:0] LEVEL_MAX  = {1'b1, {LEVEL_W{1'b0}}};
  localparam logic [LEVEL_W:0] LEVEL_ONE  = {{LEVEL_W{1'b0}}, 1'b1};
  localparam logic [LEVEL_W:0] LEVEL_ZERO = {(LEVEL_W+1){1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  // (c * lv) >> LEVEL_W; the product cannot overflow PROD_W since lv <= 2**LEVEL_W
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                    input logic [LEVEL_W:0]   lv);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lv);
    return prod[LEVEL_W +: COLOR_W];
  endfunction

  logic [N_LAYERS-1:0] act_s;
  logic [PIX_W-1:0]    or_rgb_s;
  logic [PIX_W-1:0]    pri_rgb_s;
  logic [PIX_W-1:0]    mix_rgb_s;
  logic [PIX_W-1:0]    s1_rgb_r;
  logic                s1_hs_r;
  logic                s1_vs_r;
  logic                vs_prev_r;
  logic                frame_tick_s;
  logic [CNT_W-1:0]    frame_cnt_r;
  fade_state_t         state_r;

  assign act_s        = layer_hit & layer_en;
  assign frame_tick_s = vs_prev_r & ~vsync_in;

  // Layer merge: OR of all active layers, or the lowest-index active layer
  always_comb begin
    or_rgb_s  = '0;
    pri_rgb_s = bg_rgb;
    mix_rgb_s = '0;
    // Walking downward leaves the lowest active index in pri_rgb_s
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (act_s[i]) begin
        or_rgb_s  = or_rgb_s | layer_rgb[i*PIX_W +: PIX_W];
        pri_rgb_s = layer_rgb[i*PIX_W +: PIX_W];
      end else begin
        or_rgb_s  = or_rgb_s;
        pri_rgb_s = pri_rgb_s;
      end
    end
    if (!video_on) begin
      mix_rgb_s = '0;
    end else if (act_s == '0) begin
      mix_rgb_s = bg_rgb;
    end else if (mode) begin
      mix_rgb_s = pri_rgb_s;
    end else begin
      mix_rgb_s = or_rgb_s;
    end
  end

  // Two-stage pixel pipeline: merge register, then brightness scaling
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_rgb_r  <= '0;
      s1_hs_r   <= 1'b1;
      s1_vs_r   <= 1'b1;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      s1_rgb_r  <= mix_rgb_s;
      s1_hs_r   <= hsync_in;
      s1_vs_r   <= vsync_in;
      VGA_R     <= scale_chan(s1_rgb_r[2*COLOR_W +: COLOR_W], level);
      VGA_G     <= scale_chan(s1_rgb_r[COLOR_W +: COLOR_W], level);
      VGA_B     <= scale_chan(s1_rgb_r[0 +: COLOR_W], level);
      hsync_out <= s1_hs_r;
      vsync_out <= s1_vs_r;
    end
  end

  // Previous vsync for falling-edge frame tick detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_prev_r <= 1'b1;
    end else begin
      vs_prev_r <= vsync_in;
    end
  end

  // Fade engine: steps level once every FRAMES_PER_STEP frame ticks
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      frame_cnt_r <= '0;
      level       <= LEVEL_MAX;
      fade_busy   <= 1'b0;
      fade_done   <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fade_req) begin
            if (!fade_dir) begin
              if (level != LEVEL_ZERO) begin
                state_r     <= FADE_OUT;
                frame_cnt_r <= '0;
                fade_busy   <= 1'b1;
              end else begin
                fade_done <= 1'b1;
              end
            end else begin
              if (level != LEVEL_MAX) begin
                state_r     <= FADE_IN;
                frame_cnt_r <= '0;
                fade_busy   <= 1'b1;
              end else begin
                fade_done <= 1'b1;
              end
            end
          end
        end
        FADE_OUT: begin
          if (frame_tick_s) begin
            if (frame_cnt_r == CNT_LAST) begin
              frame_cnt_r <= '0;
              level       <= level - LEVEL_ONE;
              if (level == LEVEL_ONE) begin
                state_r   <= IDLE;
                fade_busy <= 1'b0;
                fade_done <= 1'b1;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end
          end
        end
        FADE_IN: begin
          if (frame_tick_s) begin
            if (frame_cnt_r == CNT_LAST) begin
              frame_cnt_r <= '0;
              level       <= level + LEVEL_ONE;
              if (level == (LEVEL_MAX - LEVEL_ONE)) begin
                state_r   <= IDLE;
                fade_busy <= 1'b0;
                fade_done <= 1'b1;
              end
            end else begin
              frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          fade_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_layer_mixer.sv
// Scoreboard bench for rgb_layer_mixer: queued pixel expectations checked by a
// monitor at their due cycle, plus directed fade-engine and reset checks.
module tb_rgb_layer_mixer;

  localparam int NL = 4;

  logic        clk;
  logic        reset_n;
  logic [95:0] layer_rgb;
  logic [3:0]  layer_hit;
  logic [3:0]  layer_en;
  logic        mode;
  logic [23:0] bg_rgb;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        fade_req;
  logic        fade_dir;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        hsync_out;
  logic        vsync_out;
  logic        fade_busy;
  logic        fade_done;
  logic [4:0]  level;

  rgb_layer_mixer #(
    .N_LAYERS(NL), .COLOR_W(8), .LEVEL_W(4), .FRAMES_PER_STEP(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .layer_rgb(layer_rgb), .layer_hit(layer_hit),
    .layer_en(layer_en), .mode(mode), .bg_rgb(bg_rgb), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .fade_req(fade_req), .fade_dir(fade_dir),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .fade_busy(fade_busy), .fade_done(fade_done), .level(level)
  );

  typedef struct {
    int          due;
    logic [25:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   d0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the pixel/sync word due on this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          check("pixel_missed", 32'(e.due), 32'(cyc));
        end else begin
          check("pixel", {6'd0, VGA_R, VGA_G, VGA_B, hsync_out, vsync_out}, {6'd0, e.val});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (fade_done === 1'b1) done_cnt++;
    end
  end

  task automatic apply(input logic m, input logic [3:0] en, input logic [3:0] hit,
                       input logic vo, input logic [95:0] rgb, input logic [23:0] bg,
                       input logic hs, input logic vs, input logic [23:0] exp_rgb);
    exp_t e;
    @(posedge clk);
    #1;
    mode = m; layer_en = en; layer_hit = hit; video_on = vo;
    layer_rgb = rgb; bg_rgb = bg; hsync_in = hs; vsync_in = vs;
    e.due = cyc + 2;
    e.val = {exp_rgb, hs, vs};
    sb_q.push_back(e);
  endtask

  task automatic frame();
    @(posedge clk); #1 vsync_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fade_pulse(input logic dir);
    @(posedge clk); #1 fade_req = 1'b1; fade_dir = dir;
    @(posedge clk); #1 fade_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; layer_rgb = '0; layer_hit = '0; layer_en = '0; mode = 1'b0;
    bg_rgb = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    fade_req = 1'b0; fade_dir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("reset_syncs", {30'd0, hsync_out, vsync_out}, 32'h3);
    check("reset_level", 32'(level), 32'd16);
    check("reset_busy_done", {30'd0, fade_busy, fade_done}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // mode, en, hit, video_on, {l3,l2,l1,l0}, bg, hs, vs, expected
    apply(1'b0, 4'hF, 4'b0101, 1'b1, {24'h0, 24'h000020, 24'hABCDEF, 24'h100000}, 24'h777777, 1'b0, 1'b1, 24'h100020);
    apply(1'b0, 4'hF, 4'b0101, 1'b1, {24'h0, 24'h000020, 24'hABCDEF, 24'h100000}, 24'h777777, 1'b1, 1'b0, 24'h100020);
    apply(1'b1, 4'hF, 4'b1010, 1'b1, {24'h00FF00, 24'h0000AA, 24'hFF0000, 24'h0000BB}, 24'h777777, 1'b0, 1'b0, 24'hFF0000);
    apply(1'b1, 4'hD, 4'b1010, 1'b1, {24'h00FF00, 24'h0000AA, 24'hFF0000, 24'h0000BB}, 24'h777777, 1'b1, 1'b1, 24'h00FF00);
    apply(1'b0, 4'hF, 4'b0000, 1'b1, {24'h00FF00, 24'h0000AA, 24'hFF0000, 24'h0000BB}, 24'h123456, 1'b0, 1'b1, 24'h123456);
    apply(1'b1, 4'hF, 4'b0000, 1'b1, {24'h00FF00, 24'h0000AA, 24'hFF0000, 24'h0000BB}, 24'h123456, 1'b1, 1'b0, 24'h123456);
    apply(1'b0, 4'hF, 4'b1111, 1'b0, {24'h00FF00, 24'h0000AA, 24'hFF0000, 24'h0000BB}, 24'h123456, 1'b0, 1'b0, 24'h000000);
    apply(1'b0, 4'hF, 4'b0011, 1'b1, {24'h0, 24'h0, 24'hF0F00F, 24'h0F0F0F}, 24'h123456, 1'b1, 1'b1, 24'hFFFF0F);
    apply(1'b1, 4'hF, 4'b0101, 1'b1, {24'h0, 24'h0A0B0C, 24'h0, 24'h010203}, 24'h123456, 1'b0, 1'b1, 24'h010203);
    apply(1'b1, 4'h0, 4'b1111, 1'b1, {24'h0, 24'h0A0B0C, 24'h0, 24'h010203}, 24'h123456, 1'b1, 1'b1, 24'h123456);
    apply(1'b0, 4'h1, 4'b0001, 1'b1, {24'h0, 24'h0, 24'h0, 24'hFFFFFF}, 24'h123456, 1'b1, 1'b1, 24'hFFFFFF);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // Fade out from full with a constant white pixel
    d0 = done_cnt;
    fade_pulse(1'b0);
    check("fade_out_busy_start", {31'd0, fade_busy}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      frame();
      if (k == 8) fade_pulse(1'b1);
      check("fade_out_level", 32'(level), 32'(16 - k / 2));
      check("fade_out_busy", {31'd0, fade_busy}, (k < 32) ? 32'd1 : 32'd0);
      if (k == 16) check("half_level_red", 32'(VGA_R), 32'h7F);
    end
    check("fade_out_done_once", 32'(done_cnt - d0), 32'd1);
    frame();
    check("level_holds_zero", 32'(level), 32'd0);
    check("black_output", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);

    // Fade-out request at level 0: immediate done, no state change
    d0 = done_cnt;
    @(posedge clk); #1 fade_req = 1'b1; fade_dir = 1'b0;
    @(posedge clk); #1 fade_req = 1'b0;
    check("zero_req_done", {31'd0, fade_done}, 32'd1);
    check("zero_req_busy", {31'd0, fade_busy}, 32'd0);
    @(posedge clk); #1;
    check("zero_req_done_clear", {31'd0, fade_done}, 32'd0);
    check("zero_req_level", 32'(level), 32'd0);
    check("zero_req_done_once", 32'(done_cnt - d0), 32'd1);

    // Fade in back to full
    d0 = done_cnt;
    fade_pulse(1'b1);
    for (int k = 1; k <= 32; k++) begin
      frame();
      check("fade_in_level", 32'(level), 32'(k / 2));
    end
    check("fade_in_busy_end", {31'd0, fade_busy}, 32'd0);
    check("fade_in_done_once", 32'(done_cnt - d0), 32'd1);
    check("full_red_restored", 32'(VGA_R), 32'hFF);

    // Down again, then reset partway up at level 5
    fade_pulse(1'b0);
    for (int k = 1; k <= 32; k++) frame();
    check("second_fade_out_level", 32'(level), 32'd0);
    fade_pulse(1'b1);
    for (int k = 1; k <= 10; k++) frame();
    check("mid_fade_in_level", 32'(level), 32'd5);
    check("mid_fade_in_busy", {31'd0, fade_busy}, 32'd1);
    d0 = done_cnt;
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    check("abort_level", 32'(level), 32'd16);
    check("abort_busy_done", {30'd0, fade_busy, fade_done}, 32'd0);
    check("abort_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("abort_syncs", {30'd0, hsync_out, vsync_out}, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_busy_stays_low", {31'd0, fade_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_layer_mixer.md
Name: rgb_layer_mixer

Overview:
- Parametrised, pipelined successor to the flat OR-combiner that merges per-layer VGA colour sources into VGA_R/G/B.
- Adds per-layer hit/enable masking, selectable OR or priority merge, background colour, and blanking enforcement.
- Adds a frame-synchronous fade-in/fade-out brightness engine for level transitions; sync signals are delayed to stay pixel-aligned.
- Sits between the layer renderers and the VGA DAC pins.

Parameters:
- N_LAYERS, 13, number of layer inputs (1..32)
- COLOR_W, 8, bits per colour channel
- LEVEL_W, 4, brightness fraction bits; unity level = 2**LEVEL_W
- FRAMES_PER_STEP, 2, frames between brightness steps (>=1)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- layer_rgb  in  N_LAYERS*3*COLOR_W  layer i = [i*3*COLOR_W +: 3*COLOR_W], packed {R,G,B}, R in MSBs
- layer_hit  in  N_LAYERS  layer i covers the current pixel
- layer_en  in  N_LAYERS  layer i enabled (quasi-static)
- mode  in  1  0 = OR merge, 1 = priority merge (lowest index wins)
- bg_rgb  in  3*COLOR_W  background {R,G,B}
- video_on  in  1  active-video qualifier
- hsync_in  in  1  horizontal sync (active low)
- vsync_in  in  1  vertical sync (active low)
- fade_req  in  1  one-cycle fade request
- fade_dir  in  1  0 = fade to black, 1 = fade to full
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  pixel colour
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- fade_busy  out  1  high while fading
- fade_done  out  1  one-cycle pulse when a fade completes
- level  out  LEVEL_W+1  current brightness, 0..2**LEVEL_W

Behaviour:
- One clock domain. Reset is synchronous, active-low, sampled on the clk rising edge.
- Reset values: VGA_R/G/B = 0, hsync_out = 1, vsync_out = 1, fade_busy = 0, fade_done = 0, level = 2**LEVEL_W, FSM = IDLE, frame counter = 0, both pipeline stages cleared (syncs cleared to 1).
- Active set: act[i] = layer_hit[i] & layer_en[i].
- Stage 1 (registered):
  - mode 0: colour = bitwise OR of layer_rgb over active layers.
  - mode 1: colour = layer_rgb of the lowest-index active layer.
  - Either mode, no active layer: colour = bg_rgb.
  - video_on = 0: colour forced to 0, overriding the above.
- Stage 2 (registered): each channel out = (c * level) >> LEVEL_W, product width COLOR_W+LEVEL_W+1, truncated to COLOR_W. level = 2**LEVEL_W passes colour unchanged; level = 0 outputs 0.
- Latency: exactly 2 cycles from inputs to VGA_*/hsync_out/vsync_out. video_on, mode and syncs are all sampled in the same input cycle.
- Frame tick: one-cycle pulse on the vsync_in falling edge, detected from a registered previous value.
- Fade FSM, states IDLE, FADE_OUT, FADE_IN:
  - IDLE + fade_req, dir 0: go to FADE_OUT if level > 0; otherwise stay IDLE and pulse fade_done next cycle.
  - IDLE + fade_req, dir 1: go to FADE_IN if level < 2**LEVEL_W; otherwise stay IDLE and pulse fade_done next cycle.
  - On entering FADE_*, the frame counter clears to 0. Each frame tick increments it; on reaching FRAMES_PER_STEP it clears and level steps by 1 (down in FADE_OUT, up in FADE_IN).
  - When a step reaches 0 (FADE_OUT) or 2**LEVEL_W (FADE_IN): go to IDLE and pulse fade_done in the cycle after the final step.
  - fade_busy = 1 in FADE_OUT and FADE_IN.
  - fade_req while busy is ignored: no restart, no direction change.
  - level holds its value between fades; it never wraps or goes out of range.
- Reset mid-fade aborts the fade: level returns to full, no fade_done pulse.
- The level used in stage 2 is the registered level; a change applies to the pixel entering stage 2 on the following cycle.

Test Plan:
- N_LAYERS=4, mode=0, layers 0/2 hit, rgb 0x100000 and 0x000020, level full, video_on=1 -> VGA = 0x10/0x00/0x20 exactly 2 cycles later; hsync/vsync pattern delayed 2 cycles.
- mode=1, layers 1 and 3 hit, layer1 = 0xFF0000, layer3 = 0x00FF00 -> VGA = 0xFF/0x00/0x00; clear layer_en[1] -> 0x00/0xFF/0x00.
- No layer hit, bg_rgb = 0x123456 -> output 0x12/0x34/0x56; drop video_on -> 0x00/0x00/0x00 two cycles later, regardless of hits and bg.
- LEVEL_W=4, FRAMES_PER_STEP=2, fade_req dir 0, constant pixel 0xFF -> level 16->0 over 32 vsync falls; at level 8, VGA_R = 0x7F; fade_done single pulse at end; fade_busy low afterward.
- At level 0, fade_req dir 0 -> no state change, fade_done pulses next cycle. fade_req dir 1 mid-FADE_OUT -> ignored. Fade in from 0 -> reaches 16 and output returns to 0xFF.
- Assert reset_n low for 1 cycle mid-FADE_IN at level 5 -> next cycle: level = 16, fade_busy = 0, outputs 0, syncs 1, no fade_done.
